instr_fetch_unit: RTL

- Front end of the 8-bit MCU. Sits directly upstream of the control unit.
- Owns the program counter and fetches 1- or 2-byte instructions from 8-bit program memory over a req/ready handshake.
- Latches and decodes the instruction, then presents opcode, imm_mode, register fields and immediate to the control unit.
- Holds the instruction until the control unit acknowledges it, and applies jumps at that acknowledge.

---
 rtl/instr_fetch_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MCU instruction fetch/decode front end (option: FETCH_ILLEGAL_TRAP_EN)
module instr_fetch_unit #(
    parameter int                     PC_WIDTH     = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic [7:0]          mem_rdata,
    input  logic                mem_ready,
    output logic                instr_valid,
    input  logic                instr_ack,
    input  logic                jump_en,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [3:0]          opcode,
    output logic [1:0]          rd,
    output logic [1:0]          rs,
    output logic [7:0]          imm,
    output logic                imm_mode,
    output logic [PC_WIDTH-1:0] pc
`ifdef FETCH_ILLEGAL_TRAP_EN
    ,
    output logic                illegal_op
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_F1   = 2'd1,
        S_F2   = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]          OP_NOP = 4'b1111;

    state_t state;
    state_t state_nxt;

    // MOVI, JMP, LOAD and STORE carry an immediate byte
    function automatic logic is_two_byte(input logic [3:0] op);
        return (op == 4'b0101) || (op == 4'b0111) || (op == 4'b0011) || (op == 4'b0010);
    endfunction

`ifdef FETCH_ILLEGAL_TRAP_EN
    // Opcodes with no defined meaning are trapped and replaced by NOP
    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'b0110) || ((op >= 4'b1000) && (op <= 4'b1110));
    endfunction
`endif

    // The address bus always shows the PC; it only matters while mem_req is high
    assign mem_addr = pc;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-state handshake outputs
    always_comb begin
        state_nxt   = state;
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_F1;
            end
            S_F1: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_nxt = is_two_byte(mem_rdata[7:4]) ? S_F2 : S_HOLD;
                end
            end
            S_F2: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ack) begin
                    state_nxt = S_F1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // PC, decoded fields and immediate; jumps land only on an acknowledged instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_VECTOR;
            opcode     <= OP_NOP;
            rd         <= 2'd0;
            rs         <= 2'd0;
            imm        <= 8'h00;
            imm_mode   <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
            illegal_op <= 1'b0;
`endif
        end else begin
            case (state)
                S_F1: begin
                    if (mem_ready) begin
                        pc  <= pc + PC_ONE;
                        imm <= 8'h00;
`ifdef FETCH_ILLEGAL_TRAP_EN
                        if (is_illegal(mem_rdata[7:4])) begin
                            opcode     <= OP_NOP;
                            rd         <= 2'd0;
                            rs         <= 2'd0;
                            imm_mode   <= 1'b0;
                            illegal_op <= 1'b1;
                        end else begin
                            opcode     <= mem_rdata[7:4];
                            rd         <= mem_rdata[3:2];
                            rs         <= mem_rdata[1:0];
                            imm_mode   <= is_two_byte(mem_rdata[7:4]);
                            illegal_op <= 1'b0;
                        end
`else
                        opcode   <= mem_rdata[7:4];
                        rd       <= mem_rdata[3:2];
                        rs       <= mem_rdata[1:0];
                        imm_mode <= is_two_byte(mem_rdata[7:4]);
`endif
                    end
                end
                S_F2: begin
                    if (mem_ready) begin
                        pc  <= pc + PC_ONE;
                        imm <= mem_rdata;
                    end
                end
                S_HOLD: begin
                    if (instr_ack) begin
                        if (jump_en) begin
                            pc <= jump_target;
                        end
`ifdef FETCH_ILLEGAL_TRAP_EN
                        illegal_op <= 1'b0;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
